// File: rtl/fifo_param_if.sv
// Producer/consumer bundle for fifo_param: request/data lines plus status flags.
interface fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, rd, din,
        input  dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, rd, din,
        output dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with programmable almost flags, an occupancy count,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr_q, wrPtr_d;
    logic [AW-1:0]     rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              isEmpty, isFull, wrAccept, rdAccept;

    // A full FIFO still takes a write when the same edge pops the head.
    assign isEmpty  = (count_q == '0);
    assign isFull   = (count_q == CW'(DEPTH));
    assign wrAccept = bus.wr && (!isFull || bus.rd);
    assign rdAccept = bus.rd && !isEmpty;

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = bus.wr && !wrAccept;
        underflow_d = bus.rd && !rdAccept;
        if (wrAccept) wrPtr_d = wrPtr_q + AW'(1);
        if (rdAccept) rdPtr_d = rdPtr_q + AW'(1);
        if (wrAccept && !rdAccept)      count_d = count_q + CW'(1);
        else if (rdAccept && !wrAccept) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage carries no reset; stale entries are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (wrAccept) mem[wrPtr_q] <= bus.din;
    end

    generate
        if (FWFT != 0) begin : gFwft
            assign bus.dout = mem[rdPtr_q];
        end else begin : gStd
            logic [DATA_W-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rdAccept) dout_d = mem[rdPtr_q];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dout_q <= '0;
                else        dout_q <= dout_d;
            end

            assign bus.dout = dout_q;
        end
    endgenerate

    assign bus.empty        = isEmpty;
    assign bus.full         = isFull;
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: three instances (standard, FWFT, tight thresholds) checked
// every cycle against a queue-style model, plus hand-computed literal expectations.
module tb_fifo_param;
    localparam int DEPTH = 16;

    typedef enum int {F_COUNT, F_EMPTY, F_FULL, F_AF, F_AE, F_DOUT, F_OVF, F_UDF} fieldE;
    typedef struct {
        int          inst;
        fieldE       f;
        logic [31:0] val;
        string       name;
    } litT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wrS [3];
    logic       rdS [3];
    logic [7:0] dinS [3];
    logic [7:0] doutA [3];
    logic [4:0] countA [3];
    logic       emptyA [3];
    logic       fullA [3];
    logic       afA [3];
    logic       aeA [3];
    logic       ovfA [3];
    logic       udfA [3];

    int         testsRun = 0;
    int         testsFailed = 0;
    litT        litQ [$];

    // Model: every accepted word appended to a history; head/tail indices give the contents.
    logic [7:0] histM [3][1024];
    int         headM [3];
    int         tailM [3];
    logic [7:0] lastDoutM [3];
    bit         ovfM [3];
    bit         udfM [3];

    always #5 clk = ~clk;

    fifo_param_if #(.DATA_W(8), .DEPTH(DEPTH)) bus0 ();
    fifo_param_if #(.DATA_W(8), .DEPTH(DEPTH)) bus1 ();
    fifo_param_if #(.DATA_W(8), .DEPTH(DEPTH)) bus2 ();

    fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0))
        u_std (.clk(clk), .rst_n(rst_n), .bus(bus0));
    fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1))
        u_fwft (.clk(clk), .rst_n(rst_n), .bus(bus1));
    fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(4), .AE_THRESH(0), .FWFT(0))
        u_thr (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.wr = wrS[0];
    assign bus0.rd = rdS[0];
    assign bus0.din = dinS[0];
    assign bus1.wr = wrS[1];
    assign bus1.rd = rdS[1];
    assign bus1.din = dinS[1];
    assign bus2.wr = wrS[2];
    assign bus2.rd = rdS[2];
    assign bus2.din = dinS[2];

    assign doutA[0] = bus0.dout;
    assign doutA[1] = bus1.dout;
    assign doutA[2] = bus2.dout;
    assign countA[0] = bus0.count;
    assign countA[1] = bus1.count;
    assign countA[2] = bus2.count;
    assign emptyA[0] = bus0.empty;
    assign emptyA[1] = bus1.empty;
    assign emptyA[2] = bus2.empty;
    assign fullA[0] = bus0.full;
    assign fullA[1] = bus1.full;
    assign fullA[2] = bus2.full;
    assign afA[0] = bus0.almost_full;
    assign afA[1] = bus1.almost_full;
    assign afA[2] = bus2.almost_full;
    assign aeA[0] = bus0.almost_empty;
    assign aeA[1] = bus1.almost_empty;
    assign aeA[2] = bus2.almost_empty;
    assign ovfA[0] = bus0.overflow;
    assign ovfA[1] = bus1.overflow;
    assign ovfA[2] = bus2.overflow;
    assign udfA[0] = bus0.underflow;
    assign udfA[1] = bus1.underflow;
    assign udfA[2] = bus2.underflow;

    function automatic int afOf(int i);
        return (i == 2) ? 4 : 14;
    endfunction

    function automatic int aeOf(int i);
        return (i == 2) ? 0 : 2;
    endfunction

    function automatic logic [31:0] getField(int i, fieldE f);
        case (f)
            F_COUNT: return 32'(countA[i]);
            F_EMPTY: return 32'(emptyA[i]);
            F_FULL:  return 32'(fullA[i]);
            F_AF:    return 32'(afA[i]);
            F_AE:    return 32'(aeA[i]);
            F_DOUT:  return 32'(doutA[i]);
            F_OVF:   return 32'(ovfA[i]);
            F_UDF:   return 32'(udfA[i]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic checkOutput(string name, int inst, logic [31:0] act, logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s inst%0d @%0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
        end
    endtask

    task automatic updateModel(int i);
        int  n;
        bit  wOk, rOk;
        if (!rst_n) begin
            headM[i] = 0;
            tailM[i] = 0;
            lastDoutM[i] = 8'h00;
            ovfM[i] = 1'b0;
            udfM[i] = 1'b0;
        end else begin
            n = tailM[i] - headM[i];
            rOk = rdS[i] && (n > 0);
            wOk = wrS[i] && ((n < DEPTH) || rdS[i]);
            ovfM[i] = wrS[i] && !wOk;
            udfM[i] = rdS[i] && !rOk;
            if (rOk) begin
                lastDoutM[i] = histM[i][headM[i]];
                headM[i]++;
            end
            if (wOk) begin
                histM[i][tailM[i]] = dinS[i];
                tailM[i]++;
            end
        end
    endtask

    task automatic compareModel(int i);
        int n;
        n = tailM[i] - headM[i];
        checkOutput("count", i, 32'(countA[i]), 32'(n));
        checkOutput("empty", i, 32'(emptyA[i]), 32'(n == 0));
        checkOutput("full", i, 32'(fullA[i]), 32'(n == DEPTH));
        checkOutput("almost_full", i, 32'(afA[i]), 32'(n >= afOf(i)));
        checkOutput("almost_empty", i, 32'(aeA[i]), 32'(n <= aeOf(i)));
        checkOutput("overflow", i, 32'(ovfA[i]), 32'(ovfM[i]));
        checkOutput("underflow", i, 32'(udfA[i]), 32'(udfM[i]));
        if (i == 1) begin
            if (n > 0) checkOutput("dout_fwft", i, 32'(doutA[i]), 32'(histM[i][headM[i]]));
        end else begin
            checkOutput("dout", i, 32'(doutA[i]), 32'(lastDoutM[i]));
        end
    endtask

    // Compare process: inputs are stable across the negedge, so they are exactly what the
    // preceding posedge sampled; advance the model with them, then check every output.
    initial begin
        litT l;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                updateModel(i);
                compareModel(i);
            end
            while (litQ.size() > 0) begin
                l = litQ.pop_front();
                checkOutput(l.name, l.inst, getField(l.inst, l.f), l.val);
            end
        end
    end

    task automatic applyStimulus(int inst, bit w, bit r, logic [7:0] d);
        for (int i = 0; i < 3; i++) begin
            if (inst < 0 || inst == i) begin
                wrS[i] = w;
                rdS[i] = r;
                dinS[i] = d;
            end
        end
    endtask

    task automatic expectLit(int inst, fieldE f, logic [31:0] v, string name);
        litT l;
        l.inst = inst;
        l.f = f;
        l.val = v;
        l.name = name;
        litQ.push_back(l);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        applyStimulus(-1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic expectResetState();
        expectLit(0, F_COUNT, 0, "rst_count");
        expectLit(0, F_EMPTY, 1, "rst_empty");
        expectLit(0, F_AE, 1, "rst_almost_empty");
        expectLit(0, F_FULL, 0, "rst_full");
        expectLit(0, F_AF, 0, "rst_almost_full");
        expectLit(0, F_DOUT, 8'h00, "rst_dout");
        expectLit(0, F_OVF, 0, "rst_overflow");
        expectLit(0, F_UDF, 0, "rst_underflow");
    endtask

    initial begin
        applyStimulus(-1, 1'b0, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        tick();
        expectResetState();
        tick();
        rst_n = 1'b1;
        tick();

        // Fill to full, then one rejected write.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(-1, 1'b1, 1'b0, 8'(k));
            if (k == 12) expectLit(0, F_AF, 0, "af_at_13");
            if (k == 13) expectLit(0, F_AF, 1, "af_at_14");
            if (k == 14) expectLit(0, F_FULL, 0, "full_at_15");
            if (k == 15) expectLit(0, F_FULL, 1, "full_at_16");
            tick();
        end
        applyStimulus(-1, 1'b1, 1'b0, 8'hEE);
        expectLit(0, F_OVF, 1, "overflow_pulse");
        expectLit(0, F_COUNT, 16, "count_after_ovf");
        tick();
        expectLit(0, F_OVF, 0, "overflow_drop");
        tick();

        // Drain in order, then one rejected read.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(-1, 1'b0, 1'b1, 8'h00);
            expectLit(0, F_DOUT, 32'(k), "drain_data");
            if (k == 12) expectLit(0, F_AE, 0, "ae_at_3");
            if (k == 13) expectLit(0, F_AE, 1, "ae_at_2");
            if (k == 15) expectLit(0, F_EMPTY, 1, "empty_after_drain");
            tick();
        end
        applyStimulus(-1, 1'b0, 1'b1, 8'h00);
        expectLit(0, F_UDF, 1, "underflow_pulse");
        expectLit(0, F_DOUT, 8'h0F, "dout_hold_on_udf");
        tick();
        expectLit(0, F_UDF, 0, "underflow_drop");
        tick();

        // Reset mid-stream with a write in flight.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(-1, 1'b1, 1'b0, 8'(8'h11 * (k + 1)));
            tick();
        end
        applyStimulus(-1, 1'b1, 1'b0, 8'h44);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        expectResetState();
        tick();
        applyStimulus(-1, 1'b1, 1'b0, 8'h77);
        tick();
        applyStimulus(-1, 1'b0, 1'b1, 8'h00);
        expectLit(0, F_DOUT, 8'h77, "first_after_reset");
        expectLit(0, F_COUNT, 0, "count_after_reset_rd");
        tick();

        // Simultaneous read/write on empty, then on full.
        applyStimulus(-1, 1'b1, 1'b1, 8'h33);
        expectLit(0, F_COUNT, 1, "simul_empty_count");
        expectLit(0, F_UDF, 1, "simul_empty_udf");
        tick();
        applyStimulus(-1, 1'b0, 1'b1, 8'h00);
        expectLit(0, F_DOUT, 8'h33, "simul_empty_data");
        tick();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(-1, 1'b1, 1'b0, 8'(8'h80 + k));
            tick();
        end
        applyStimulus(-1, 1'b1, 1'b1, 8'hAA);
        expectLit(0, F_COUNT, 16, "simul_full_count");
        expectLit(0, F_OVF, 0, "simul_full_no_ovf");
        expectLit(0, F_DOUT, 8'h80, "simul_full_head");
        expectLit(1, F_DOUT, 8'h81, "simul_full_fwft_head");
        tick();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(-1, 1'b0, 1'b1, 8'h00);
            if (k == 15) expectLit(0, F_DOUT, 8'hAA, "simul_full_tail");
            tick();
        end

        // Alternating bursts across the pointer wrap.
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 10; k++) begin
                if (b % 2 == 0) applyStimulus(-1, 1'b1, 1'b0, 8'(8'h40 + b * 10 + k));
                else            applyStimulus(-1, 1'b0, 1'b1, 8'h00);
                if (b == 0 && k == 9) expectLit(0, F_COUNT, 10, "wrap_count_10");
                if (b == 3 && k == 0) expectLit(0, F_DOUT, 8'h54, "wrap_first_rd");
                tick();
            end
        end

        // FWFT: head visible as soon as empty falls.
        applyStimulus(1, 1'b1, 1'b0, 8'h5A);
        expectLit(1, F_DOUT, 8'h5A, "fwft_dout");
        expectLit(1, F_EMPTY, 0, "fwft_not_empty");
        tick();
        applyStimulus(1, 1'b0, 1'b1, 8'h00);
        expectLit(1, F_EMPTY, 1, "fwft_empty_after_rd");
        expectLit(1, F_COUNT, 0, "fwft_count_after_rd");
        tick();

        // Tight thresholds on the third instance.
        expectLit(2, F_AE, 1, "thr_ae_at_0");
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2, 1'b1, 1'b0, 8'(8'hC0 + k));
            if (k == 0) expectLit(2, F_AE, 0, "thr_ae_fall");
            if (k == 2) expectLit(2, F_AF, 0, "thr_af_at_3");
            if (k == 3) expectLit(2, F_AF, 1, "thr_af_at_4");
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2, 1'b0, 1'b1, 8'h00);
            if (k == 3) expectLit(2, F_DOUT, 8'hC3, "thr_last_data");
            tick();
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the team's 8-bit FIFO. Generalises data width and depth, adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in one clock domain and keeps the existing wr/rd/din/dout/empty/full port set, so current driver and monitor clocking blocks bind to it unchanged.

## Interface
- DATA_W, 8: data width in bits (≥1)
- DEPTH, 16: number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-low reset
- wr  input  1  write request
- rd  input  1  read request
- din  input  DATA_W  write data, sampled with wr
- dout  output  DATA_W  read data
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_full  output  1  count ≥ AF_THRESH
- almost_empty  output  1  count ≤ AE_THRESH
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write rejected
- underflow  output  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH×DATA_W array, not reset. Write and read pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Accept rules, evaluated at each rising clk edge:
  - Write accepted when wr && (!full || rd).
  - Read accepted when rd && !empty.
- Full with wr && rd: both accepted and count is unchanged. This holds in both modes.
- Empty with wr && rd: the write is accepted, the read is rejected, and underflow pulses.
- wr && full && !rd: write dropped, pointers unchanged, overflow pulses for one cycle.
- rd && empty: read dropped, underflow pulses. In standard mode dout holds its value.
- count update: +1 on accepted write only, −1 on accepted read only, otherwise unchanged.
- Flags decode combinationally from the count register, so they are glitch-free relative to clk.
- Standard mode (FWFT=0): dout is a register loaded with mem[rd_ptr] on an accepted read. It holds otherwise.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] whenever !empty, with no register stage. rd pops the head. dout is don't-care while empty.
- Reset (rst low, asynchronous assert; deassert synchronised by the system) forces:
  - pointers = 0, count = 0
  - empty = 1, full = 0, almost_empty = 1
  - almost_full = 0
  - overflow = 0, underflow = 0
  - dout = 0 (standard mode)
- Reset mid-operation discards all contents. The first post-reset write lands at address 0.

## Timing
- Write at edge N: count, empty and the almost flags reflect it after edge N.
- Standard read issued at edge M: new dout is valid after edge M, so a monitor samples it at edge M+1.
- FWFT: the first word is visible on dout in the same cycle empty falls, i.e. after the write edge.
- overflow and underflow are registered pulses, high for exactly the cycle following the offending edge.
- No combinational path from wr/rd to full/empty/count. In FWFT mode the only combinational path is pointer → dout.
- Throughput: one write and one read per cycle sustained, at any occupancy 1..DEPTH-1.

## Test plan
- Reset/defaults: DATA_W=8, DEPTH=16, hold rst low mid-stream for 2 cycles, then release -> count=0, empty=1, almost_empty=1, full=0, dout=0x00, no pulses; the next write lands at address 0.
- Fill/drain: write 0x00..0x0F, then 1 extra write -> full=1 after the 16th; almost_full rises at count=14; one overflow pulse; count stays 16. Read 16 -> data 0x00..0x0F in order; almost_empty rises at count=2; empty=1. A 17th read -> one underflow pulse, dout holds 0x0F.
- Wrap-around: 40 cycles of alternating bursts of 10 writes and 10 reads -> data order preserved across pointer wrap; count never exceeds 10.
- Simultaneous: at count=16 drive wr=1 (din=0xAA) and rd=1 -> head read out, 0xAA accepted, count=16, no overflow. At count=0 drive wr=1 and rd=1 -> count=1, underflow pulse.
- FWFT=1: write 0x5A into an empty FIFO -> dout=0x5A in the cycle after the write edge, with empty=0; rd=1 -> empty=1, count=0.
- Thresholds: set AF_THRESH=4, AE_THRESH=0 and write 4 words -> almost_empty falls after the 1st write; almost_full rises after the 4th.
